// File: rtl/m_depp_host.sv
// m_depp_host: host (initiator) end of the Digilent DEPP parallel port,
// presented as a Wishbone classic slave. Each Wishbone access runs one
// DEPP address cycle (ADR_I[0]=0) or data cycle (ADR_I[0]=1) on the pads;
// ADR_I[1]=1 selects the local status register (bit 0 = timeout flag).
//
// Ports:
//   CLK_I, RST_I        clock, synchronous active-high reset
//   STB_I, WE_I, ADR_I  Wishbone request (STB held until ACK_O)
//   DAT_I / DAT_O       write data / read data (valid while ACK_O)
//   ACK_O               single-cycle acknowledge
//   padnADDRSTB/padnDATASTB/padnWRITE   DEPP control pads (active low)
//   padDB_O/padDB_OE/padDB_I            split bidirectional data bus
//   padnWAIT            peripheral handshake, asynchronous
module m_depp_host #(
  parameter int unsigned SETUPCYC = 2,
  parameter int unsigned TMOW     = 10
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic [1:0] ADR_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  output logic       padnADDRSTB,
  output logic       padnDATASTB,
  output logic       padnWRITE,
  output logic [7:0] padDB_O,
  output logic       padDB_OE,
  input  logic [7:0] padDB_I,
  input  logic       padnWAIT
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_ACK
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUPCYC);

  state_t          state_q, state_d;
  logic [3:0]      setup_cnt_q, setup_cnt_d;
  logic [TMOW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic            we_q, we_d;
  logic            sel_q, sel_d;
  logic            tmo_q, tmo_d;
  logic            ack_q, ack_d;
  logic [7:0]      dat_o_q, dat_o_d;
  logic            naddr_q, naddr_d;
  logic            ndata_q, ndata_d;
  logic            nwrite_q, nwrite_d;
  logic            oe_q, oe_d;
  logic [7:0]      db_o_q, db_o_d;
  logic            wsync1_q, wsync_q;

  // Pad and ACK flops are loaded from the next-state decision so they change
  // on the same edge as the state register and never glitch.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    we_d        = we_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    ack_d       = 1'b0;
    dat_o_d     = dat_o_q;
    naddr_d     = naddr_q;
    ndata_d     = ndata_q;
    nwrite_d    = nwrite_q;
    oe_d        = oe_q;
    db_o_d      = db_o_q;
    // The phase times out on the edge where the counter reaches all-ones.
    tmo_inc     = tmo_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (STB_I) begin
          if (ADR_I[1]) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (WE_I) tmo_d   = 1'b0;
            else      dat_o_d = {7'b0, tmo_q};
          end else begin
            state_d     = S_SETUP;
            we_d        = WE_I;
            sel_d       = ADR_I[0];
            db_o_d      = DAT_I;
            setup_cnt_d = '0;
            nwrite_d    = ~WE_I;
            oe_d        = WE_I;
          end
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d   = S_STROBE;
          tmo_cnt_d = '0;
          if (sel_q) ndata_d = 1'b0;
          else       naddr_d = 1'b0;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      S_STROBE, S_RELEASE: begin
        tmo_cnt_d = tmo_inc;
        if (state_q == S_STROBE && wsync_q) begin
          state_d   = S_RELEASE;
          tmo_cnt_d = '0;
          naddr_d   = 1'b1;
          ndata_d   = 1'b1;
          if (!we_q) dat_o_d = padDB_I;
        end else if (state_q == S_RELEASE && !wsync_q) begin
          state_d  = S_ACK;
          ack_d    = 1'b1;
          nwrite_d = 1'b1;
          oe_d     = 1'b0;
        end else if (&tmo_inc) begin
          state_d  = S_ACK;
          ack_d    = 1'b1;
          tmo_d    = 1'b1;
          naddr_d  = 1'b1;
          ndata_d  = 1'b1;
          nwrite_d = 1'b1;
          oe_d     = 1'b0;
          if (!we_q) dat_o_d = 8'hFF;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      we_q        <= 1'b0;
      sel_q       <= 1'b0;
      tmo_q       <= 1'b0;
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
      naddr_q     <= 1'b1;
      ndata_q     <= 1'b1;
      nwrite_q    <= 1'b1;
      oe_q        <= 1'b0;
      db_o_q      <= '0;
      wsync1_q    <= 1'b0;
      wsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      naddr_q     <= naddr_d;
      ndata_q     <= ndata_d;
      nwrite_q    <= nwrite_d;
      oe_q        <= oe_d;
      db_o_q      <= db_o_d;
      wsync1_q    <= padnWAIT;
      wsync_q     <= wsync1_q;
    end
  end

  assign DAT_O       = dat_o_q;
  assign ACK_O       = ack_q;
  assign padnADDRSTB = naddr_q;
  assign padnDATASTB = ndata_q;
  assign padnWRITE   = nwrite_q;
  assign padDB_O     = db_o_q;
  assign padDB_OE    = oe_q;

endmodule

// File: tb/tb_m_depp_host.sv
// Directed bench for m_depp_host with a behavioural DEPP peripheral:
// 16-byte register file, address register, programmable wait delay and
// wait modes (0 normal, 1 never raise wait, 2 raise and hold wait high).
module tb_m_depp_host;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       STB_I = 1'b0;
  logic       WE_I  = 1'b0;
  logic [1:0] ADR_I = 2'b00;
  logic [7:0] DAT_I = 8'h00;
  logic [7:0] DAT_O;
  logic       ACK_O;
  logic       padnADDRSTB, padnDATASTB, padnWRITE, padDB_OE;
  logic [7:0] padDB_O, padDB_I;
  logic       padnWAIT;

  int checks = 0;
  int errors = 0;

  m_depp_host #(.SETUPCYC(2), .TMOW(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .padnADDRSTB(padnADDRSTB), .padnDATASTB(padnDATASTB), .padnWRITE(padnWRITE),
    .padDB_O(padDB_O), .padDB_OE(padDB_OE), .padDB_I(padDB_I), .padnWAIT(padnWAIT)
  );

  always #5 CLK_I = ~CLK_I;

  // ---------------- peripheral model ----------------
  logic        m_rst = 1'b1;
  int unsigned wait_dly = 0;
  int          mode = 0;
  int unsigned dly_cnt;
  logic        nwait_r;
  logic [7:0]  m_addr;
  logic [7:0]  mem [0:15];
  logic [7:0]  hist [0:31];
  int          wr_cnt;

  assign padnWAIT = nwait_r;
  assign padDB_I  = mem[m_addr[3:0]];

  always @(posedge CLK_I) begin
    if (m_rst) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[7]  <= 8'h3C;
      nwait_r <= 1'b0;
      dly_cnt <= 0;
      wr_cnt  <= 0;
      m_addr  <= 8'h00;
    end else if (!padnADDRSTB || !padnDATASTB) begin
      if (mode != 1) begin
        if (dly_cnt >= wait_dly) begin
          if (!nwait_r) begin
            nwait_r <= 1'b1;
            if (!padnWRITE) begin
              if (!padnADDRSTB) m_addr <= padDB_O;
              else begin
                mem[m_addr[3:0]] <= padDB_O;
                hist[wr_cnt % 32] <= padDB_O;
                wr_cnt <= wr_cnt + 1;
              end
            end
          end
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end
    end else begin
      dly_cnt <= 0;
      if (mode != 2) nwait_r <= 1'b0;
    end
  end

  // ---------------- pad monitor ----------------
  int ack_cnt = 0, addr_low_cnt = 0, data_low_cnt = 0, oe_cnt = 0, mon_viol = 0;

  always @(negedge CLK_I) begin
    if (ACK_O) ack_cnt++;
    if (!padnADDRSTB) addr_low_cnt++;
    if (!padnDATASTB) data_low_cnt++;
    if (padDB_OE) oe_cnt++;
    if (!padnADDRSTB && !padnDATASTB) mon_viol++;
    if (padDB_OE && padnWRITE) mon_viol++;
    if (ACK_O && (padDB_OE || !padnADDRSTB || !padnDATASTB)) mon_viol++;
  end

  // One Wishbone access. Returns read data and pad state {nADDR,nDATA,OE,nWRITE}
  // sampled in the ACK cycle; without keep_stb, one idle cycle follows.
  task automatic access(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input bit keep_stb, output logic [7:0] rdata,
                        output logic [3:0] pads, output bit got_ack);
    STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    got_ack = 1'b0; rdata = '0; pads = '0;
    for (int n = 0; n < 200; n++) begin
      @(posedge CLK_I); #1;
      if (ACK_O) begin
        got_ack = 1'b1;
        rdata = DAT_O;
        pads = {padnADDRSTB, padnDATASTB, padDB_OE, padnWRITE};
        break;
      end
    end
    if (!keep_stb) begin
      STB_I = 1'b0;
      @(posedge CLK_I); #1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] rd; logic [3:0] pads; bit ok;
    RST_I = 1'b1; m_rst = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1;
    checks++; if (padnADDRSTB !== 1'b1) begin errors++; $display("FAIL reset_naddrstb got %b want 1", padnADDRSTB); end
    checks++; if (padnDATASTB !== 1'b1) begin errors++; $display("FAIL reset_ndatastb got %b want 1", padnDATASTB); end
    checks++; if (padnWRITE !== 1'b1) begin errors++; $display("FAIL reset_nwrite got %b want 1", padnWRITE); end
    checks++; if (padDB_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", padDB_OE); end
    checks++; if (padDB_O !== 8'h00) begin errors++; $display("FAIL reset_db_o got %h want 00", padDB_O); end
    checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ACK_O); end
    checks++; if (DAT_O !== 8'h00) begin errors++; $display("FAIL reset_dat_o got %h want 00", DAT_O); end
    RST_I = 1'b0; m_rst = 1'b0;
    @(posedge CLK_I); #1;
    access(1'b0, 2'b10, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL reset_status ack=%0d got %h want 00", ok, rd); end
  endtask

  task automatic test_write_path;
    logic [7:0] rd; logic [3:0] pads; bit ok;
    int a0, d0, k0, o0;
    mode = 0; wait_dly = 2;
    a0 = addr_low_cnt; d0 = data_low_cnt; k0 = ack_cnt; o0 = oe_cnt;
    access(1'b1, 2'b00, 8'h05, 1'b0, rd, pads, ok);
    checks++; if (!ok || ack_cnt - k0 != 1) begin errors++; $display("FAIL addr_wr_ack got %0d acks want 1", ack_cnt - k0); end
    checks++; if (addr_low_cnt == a0 || data_low_cnt != d0) begin errors++; $display("FAIL addr_wr_strobe addr_low %0d data_low %0d want >0 and 0", addr_low_cnt - a0, data_low_cnt - d0); end
    checks++; if (oe_cnt == o0) begin errors++; $display("FAIL addr_wr_oe got 0 OE cycles want >0"); end
    checks++; if (m_addr !== 8'h05) begin errors++; $display("FAIL addr_wr_reg got %h want 05", m_addr); end
    checks++; if (pads !== 4'b1101) begin errors++; $display("FAIL addr_wr_pads_at_ack got %b want 1101", pads); end
    a0 = addr_low_cnt; d0 = data_low_cnt; k0 = ack_cnt;
    access(1'b1, 2'b01, 8'hA5, 1'b0, rd, pads, ok);
    checks++; if (!ok || ack_cnt - k0 != 1) begin errors++; $display("FAIL data_wr_ack got %0d acks want 1", ack_cnt - k0); end
    checks++; if (data_low_cnt == d0 || addr_low_cnt != a0) begin errors++; $display("FAIL data_wr_strobe data_low %0d addr_low %0d want >0 and 0", data_low_cnt - d0, addr_low_cnt - a0); end
    checks++; if (mem[5] !== 8'hA5) begin errors++; $display("FAIL data_wr_reg5 got %h want a5", mem[5]); end
    checks++; if (padDB_OE !== 1'b0 || padnWRITE !== 1'b1) begin errors++; $display("FAIL data_wr_idle_pads oe %b nwrite %b want 0 1", padDB_OE, padnWRITE); end
  endtask

  task automatic test_read_delay;
    logic [7:0] rd; logic [3:0] pads; bit ok;
    int o0, d0;
    mode = 0; wait_dly = 0;
    access(1'b1, 2'b00, 8'h07, 1'b0, rd, pads, ok);
    wait_dly = 7;
    o0 = oe_cnt; d0 = data_low_cnt;
    access(1'b0, 2'b01, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (!ok || rd !== 8'h3C) begin errors++; $display("FAIL read_data ack=%0d got %h want 3c", ok, rd); end
    checks++; if (oe_cnt != o0) begin errors++; $display("FAIL read_oe got %0d OE cycles want 0", oe_cnt - o0); end
    checks++; if (data_low_cnt - d0 != 11) begin errors++; $display("FAIL read_strobe_len got %0d want 11", data_low_cnt - d0); end
  endtask

  task automatic test_timeout_strobe;
    logic [7:0] rd; logic [3:0] pads; bit ok;
    int d0;
    mode = 1;
    d0 = data_low_cnt;
    access(1'b0, 2'b01, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (!ok || rd !== 8'hFF) begin errors++; $display("FAIL tmo_read ack=%0d got %h want ff", ok, rd); end
    checks++; if (data_low_cnt - d0 != 15) begin errors++; $display("FAIL tmo_strobe_len got %0d want 15", data_low_cnt - d0); end
    checks++; if (pads !== 4'b1101) begin errors++; $display("FAIL tmo_pads_at_ack got %b want 1101", pads); end
    mode = 0;
    access(1'b0, 2'b10, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (!ok || rd !== 8'h01) begin errors++; $display("FAIL tmo_status_set got %h want 01", rd); end
    access(1'b1, 2'b10, 8'h00, 1'b0, rd, pads, ok);
    access(1'b0, 2'b10, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL tmo_status_clr got %h want 00", rd); end
  endtask

  task automatic test_timeout_release;
    logic [7:0] rd; logic [3:0] pads; bit ok;
    mode = 2; wait_dly = 0;
    access(1'b1, 2'b01, 8'h77, 1'b0, rd, pads, ok);
    checks++; if (!ok || pads !== 4'b1101) begin errors++; $display("FAIL rel_tmo_ack ack=%0d pads %b want 1101", ok, pads); end
    access(1'b0, 2'b10, 8'h00, 1'b0, rd, pads, ok);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rel_tmo_status got %h want 01", rd); end
    mode = 0;
    repeat (4) @(posedge CLK_I);
    #1;
    access(1'b1, 2'b10, 8'h00, 1'b0, rd, pads, ok);
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; logic [3:0] pads; bit ok, seen;
    int k0;
    mode = 0; wait_dly = 10;
    k0 = ack_cnt; seen = 1'b0;
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'b01; DAT_I = 8'h99;
    for (int n = 0; n < 50; n++) begin
      @(posedge CLK_I); #1;
      if (!padnDATASTB) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_strobe got none want low"); end
    RST_I = 1'b1; STB_I = 1'b0;
    @(posedge CLK_I); #1;
    checks++; if ({padnADDRSTB, padnDATASTB, padDB_OE, padnWRITE, ACK_O} !== 5'b11010) begin
      errors++; $display("FAIL rst_mid_pads got %b want 11010", {padnADDRSTB, padnDATASTB, padDB_OE, padnWRITE, ACK_O}); end
    RST_I = 1'b0;
    repeat (5) @(posedge CLK_I);
    #1;
    checks++; if (ack_cnt != k0) begin errors++; $display("FAIL rst_mid_noack got %0d acks want 0", ack_cnt - k0); end
    wait_dly = 1;
    access(1'b1, 2'b00, 8'h0C, 1'b0, rd, pads, ok);
    access(1'b1, 2'b01, 8'h5A, 1'b0, rd, pads, ok);
    checks++; if (!ok || mem[12] !== 8'h5A) begin errors++; $display("FAIL rst_mid_after ack=%0d got %h want 5a", ok, mem[12]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd; logic [3:0] pads; bit ok1, ok2;
    int k0, w0;
    mode = 0; wait_dly = 0;
    access(1'b1, 2'b00, 8'h09, 1'b0, rd, pads, ok1);
    k0 = ack_cnt; w0 = wr_cnt;
    access(1'b1, 2'b01, 8'h11, 1'b1, rd, pads, ok1);
    access(1'b1, 2'b01, 8'h22, 1'b0, rd, pads, ok2);
    checks++; if (!ok1 || !ok2 || ack_cnt - k0 != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", ack_cnt - k0); end
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("FAIL b2b_writes got %0d want 2", wr_cnt - w0); end
    checks++; if (hist[w0 % 32] !== 8'h11 || hist[(w0 + 1) % 32] !== 8'h22) begin
      errors++; $display("FAIL b2b_values got %h %h want 11 22", hist[w0 % 32], hist[(w0 + 1) % 32]); end
  endtask

  task automatic test_invariants;
    checks++; if (mon_viol != 0) begin errors++; $display("FAIL pad_invariants got %0d violations want 0", mon_viol); end
  endtask

  initial begin
    test_reset;
    test_write_path;
    test_read_delay;
    test_timeout_strobe;
    test_timeout_release;
    test_reset_mid;
    test_back_to_back;
    test_invariants;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
